// File: rtl/hazard_fwd_ctrl_pkg.sv
// Shared types for the merged hazard/forwarding controller: forwarding selects,
// MUL/DIV wait states and the hard-wired zero register address.
package hazard_pkg;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_MEM = 2'b01,
        FWD_WB  = 2'b10
    } fwd_sel_e;

    typedef enum logic {
        RUN     = 1'b0,
        MD_WAIT = 1'b1
    } md_state_e;

    localparam int unsigned REG_ZERO = 0;

endpackage

// File: rtl/hazard_fwd_ctrl_if.sv
// Pipeline-side bundle for hazard_fwd_ctrl: stage register fields in,
// stall/bubble/flush/forwarding controls out.
interface hazard_fwd_ctrl_if #(
    parameter int NUM_SRC = 2,
    parameter int AW      = 5
);
    logic                   id_valid;
    logic [NUM_SRC*AW-1:0]  id_rs;
    logic [NUM_SRC-1:0]     id_rs_used;
    logic                   id_is_md;
    logic [NUM_SRC*AW-1:0]  ex_rs;
    logic [AW-1:0]          ex_rd;
    logic                   ex_we;
    logic                   ex_is_load;
    logic                   ex_br_taken;
    logic [AW-1:0]          mem_rd;
    logic                   mem_we;
    logic [AW-1:0]          wb_rd;
    logic                   wb_we;

    logic                   pc_stall;
    logic                   if_id_stall;
    logic                   if_id_flush;
    logic                   id_ex_bubble;
    logic                   ex_hold;
    logic                   ex_mem_bubble;
    logic [2*NUM_SRC-1:0]   fwd_sel;
    logic                   md_busy;

    modport master (
        output id_valid, id_rs, id_rs_used, id_is_md, ex_rs, ex_rd, ex_we,
               ex_is_load, ex_br_taken, mem_rd, mem_we, wb_rd, wb_we,
        input  pc_stall, if_id_stall, if_id_flush, id_ex_bubble, ex_hold,
               ex_mem_bubble, fwd_sel, md_busy
    );

    modport slave (
        input  id_valid, id_rs, id_rs_used, id_is_md, ex_rs, ex_rd, ex_we,
               ex_is_load, ex_br_taken, mem_rd, mem_we, wb_rd, wb_we,
        output pc_stall, if_id_stall, if_id_flush, id_ex_bubble, ex_hold,
               ex_mem_bubble, fwd_sel, md_busy
    );
endinterface

// File: rtl/hazard_fwd_ctrl_fwd_sel.sv
// Per-operand EX forwarding select: MEM result beats WB data, register 0 never forwards.
module fwd_sel_unit
    import hazard_pkg::*;
#(
    parameter int AW = 5
) (
    input  logic [AW-1:0] rs,
    input  logic [AW-1:0] mem_rd,
    input  logic          mem_we,
    input  logic [AW-1:0] wb_rd,
    input  logic          wb_we,
    output fwd_sel_e      sel
);
    always_comb begin
        sel = FWD_RF;
        if (rs != AW'(REG_ZERO)) begin
            if (mem_we && rs == mem_rd)
                sel = FWD_MEM;
            else if (wb_we && rs == wb_rd)
                sel = FWD_WB;
        end
    end
endmodule

// File: rtl/hazard_fwd_ctrl.sv
// Merged hazard detection, branch flush, MUL/DIV wait FSM and EX forwarding control.
// Optional HAZARD_PERF_CNT_EN adds saturating load-stall / MD-stall / flush counters.
module hazard_fwd_ctrl
    import hazard_pkg::*;
#(
    parameter int NUM_REGS   = 32,
    parameter int NUM_SRC    = 2,
    parameter int MD_LATENCY = 4
) (
    input  logic                clk,
    input  logic                rst,
    hazard_fwd_ctrl_if.slave    bus
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0]         perf_load_stalls,
    output logic [31:0]         perf_md_stalls,
    output logic [31:0]         perf_flushes
`endif
);
    localparam int AW = $clog2(NUM_REGS);

    logic [NUM_SRC-1:0][1:0] sel_arr;

    for (genvar k = 0; k < NUM_SRC; k++) begin : g_fwd
        fwd_sel_e sel_k;
        fwd_sel_unit #(.AW(AW)) u_fwd (
            .rs     (bus.ex_rs[k*AW +: AW]),
            .mem_rd (bus.mem_rd),
            .mem_we (bus.mem_we),
            .wb_rd  (bus.wb_rd),
            .wb_we  (bus.wb_we),
            .sel    (sel_k)
        );
        assign sel_arr[k] = sel_k;
    end

    assign bus.fwd_sel = sel_arr;

    logic lu_match;
    logic lu_raw;

    always_comb begin
        lu_match = 1'b0;
        for (int k = 0; k < NUM_SRC; k++)
            if (bus.id_rs_used[k] && bus.id_rs[k*AW +: AW] == bus.ex_rd)
                lu_match = 1'b1;
    end

    assign lu_raw = bus.id_valid && bus.ex_is_load && bus.ex_we &&
                    (bus.ex_rd != AW'(REG_ZERO)) && lu_match;

    md_state_e  state, state_nxt;
    logic [7:0] md_cnt, md_cnt_nxt;
    logic       load_use;
    logic       md_issue;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= RUN;
            md_cnt <= '0;
        end else begin
            state  <= state_nxt;
            md_cnt <= md_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt         = state;
        md_cnt_nxt        = md_cnt;
        load_use          = 1'b0;
        md_issue          = 1'b0;
        bus.pc_stall      = 1'b0;
        bus.if_id_stall   = 1'b0;
        bus.if_id_flush   = 1'b0;
        bus.id_ex_bubble  = 1'b0;
        bus.ex_hold       = 1'b0;
        bus.ex_mem_bubble = 1'b0;
        bus.md_busy       = 1'b0;
        case (state)
            RUN: begin
                // a taken branch squashes the ID instruction, so its hazard is moot
                load_use         = lu_raw && !bus.ex_br_taken;
                bus.pc_stall     = load_use;
                bus.if_id_stall  = load_use;
                bus.if_id_flush  = bus.ex_br_taken;
                bus.id_ex_bubble = load_use || bus.ex_br_taken;
                md_issue = bus.id_valid && bus.id_is_md && !load_use && !bus.ex_br_taken;
                if (md_issue && MD_LATENCY > 1) begin
                    state_nxt  = MD_WAIT;
                    md_cnt_nxt = 8'(MD_LATENCY - 1);
                end
            end
            MD_WAIT: begin
                bus.pc_stall      = 1'b1;
                bus.if_id_stall   = 1'b1;
                bus.ex_hold       = 1'b1;
                bus.ex_mem_bubble = 1'b1;
                bus.md_busy       = 1'b1;
                md_cnt_nxt        = md_cnt - 8'd1;
                if (md_cnt == 8'd1)
                    state_nxt = RUN;
            end
            default: state_nxt = RUN;
        endcase
    end

`ifdef HAZARD_PERF_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_load_stalls <= '0;
            perf_md_stalls   <= '0;
            perf_flushes     <= '0;
        end else begin
            if (load_use && perf_load_stalls != '1)
                perf_load_stalls <= perf_load_stalls + 32'd1;
            if (bus.md_busy && perf_md_stalls != '1)
                perf_md_stalls <= perf_md_stalls + 32'd1;
            if (bus.if_id_flush && perf_flushes != '1)
                perf_flushes <= perf_flushes + 32'd1;
        end
    end
`endif

endmodule

// File: doc/hazard_fwd_ctrl.md
Name: hazard_fwd_ctrl

Overview:
Parametrised successor to the 5-stage core's separate hazard-detection and forwarding units, merged into one block. Generalised to NUM_SRC source operands and a configurable register-file size. Adds a multi-cycle MUL/DIV wait state machine and branch-flush control, which the earlier units lack. Sits beside the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers and drives their stall, bubble and flush controls plus the EX-stage operand forwarding muxes.

Parameters:
NUM_REGS, 32, architectural register count; register 0 is hard-wired zero.
AW, $clog2(NUM_REGS), register address width (derived; do not override).
NUM_SRC, 2, source operands per instruction (1..4).
MD_LATENCY, 4, EX-stage cycles taken by a MUL/DIV op (1..255).

Ports:
clk  in  1  core clock; all state on rising edge
rst  in  1  reset; asynchronous, active-high
id_valid  in  1  ID stage holds a valid instruction
id_rs  in  NUM_SRC*AW  ID source addresses; operand k is bits [k*AW +: AW]
id_rs_used  in  NUM_SRC  operand k is actually read
id_is_md  in  1  ID instruction is MUL/DIV
ex_rs  in  NUM_SRC*AW  EX source addresses
ex_rd  in  AW  EX destination
ex_we  in  1  EX writes a register
ex_is_load  in  1  EX instruction is a load
ex_br_taken  in  1  EX branch/jump resolved taken
mem_rd  in  AW  MEM destination
mem_we  in  1  MEM writes a register
wb_rd  in  AW  WB destination
wb_we  in  1  WB writes a register
pc_stall  out  1  hold PC
if_id_stall  out  1  hold IF/ID
if_id_flush  out  1  clear IF/ID to NOP
id_ex_bubble  out  1  load NOP into ID/EX
ex_hold  out  1  hold ID/EX contents (MD in progress)
ex_mem_bubble  out  1  load NOP into EX/MEM
fwd_sel  out  2*NUM_SRC  per-operand select: 00 regfile, 01 MEM ALU result, 10 WB data
md_busy  out  1  FSM is in MD_WAIT

Behaviour:
- Reset: FSM = RUN, md_cnt = 0. All outputs then evaluate combinationally to 0, including fwd_sel, provided the write enables are 0.
- Forwarding is combinational. For each operand k, a match on addr 0 never forwards.
  - ex_rs[k] == mem_rd && mem_we → 01.
  - Else ex_rs[k] == wb_rd && wb_we → 10.
  - Else → 00. MEM has priority over WB.
- Load-use hazard (combinational): in RUN, with id_valid && ex_is_load && ex_we && ex_rd != 0, and any k where id_rs_used[k] && id_rs[k] == ex_rd.
  - Response: pc_stall = if_id_stall = id_ex_bubble = 1 for that cycle.
  - Exactly one stall cycle per load; the dependent then takes 10 from WB.
- Branch flush: in RUN, ex_br_taken → if_id_flush = id_ex_bubble = 1 in that cycle, no stall.
  - Flush has priority over a simultaneous load-use hazard (the hazard is suppressed) and over MD issue.
- FSM states: RUN, MD_WAIT.
  - RUN → MD_WAIT on md_issue = id_valid && id_is_md && !load_use && !ex_br_taken && !pc_stall, only when MD_LATENCY > 1. md_cnt loads MD_LATENCY-1 at that edge.
  - MD_WAIT: md_cnt decrements each cycle. pc_stall = if_id_stall = ex_hold = ex_mem_bubble = md_busy = 1. Load-use and flush logic are ignored.
  - MD_WAIT → RUN on the edge where md_cnt == 1. The op's final EX cycle then runs in RUN with no stall.
  - MD_LATENCY == 1: no MD_WAIT entry; MD behaves as a single-cycle op.
- Back-to-back MD ops: the second issues from RUN after the first completes; each gets the full latency.
- Reset asserted mid-MD_WAIT: immediately RUN, md_cnt = 0, all stalls drop.
- Counter width 8 bits; MD_LATENCY-1 fits, and the counter never wraps.

Optional Feature:
HAZARD_PERF_CNT_EN
- Defined: adds three 32-bit saturating counters, cleared by rst:
  - perf_load_stalls: +1 per load-use stall cycle.
  - perf_md_stalls: +1 per MD_WAIT cycle.
  - perf_flushes: +1 per flush cycle.
  - Exposed as extra output ports; each saturates at 0xFFFFFFFF.
- Undefined: counters and ports absent; behaviour otherwise identical.

Decomposition:
- Package hazard_pkg: fwd_sel_e enum (FWD_RF=2'b00, FWD_MEM=2'b01, FWD_WB=2'b10), md_state_e (RUN, MD_WAIT), REG_ZERO constant.
- One sub-module, fwd_sel_unit: combinational per-operand priority compare, instantiated NUM_SRC times via generate.
- FSM, counter and stall/flush logic stay in the top module.

Test Plan:
- Reset: rst=1 mid-MD_WAIT (md_cnt=2) → next sample md_busy=0, pc_stall=0; after release FSM in RUN.
- Forward priority: ex_rs[0]=5, mem_rd=5/mem_we=1, wb_rd=5/wb_we=1 → fwd_sel[1:0]=01. Drop mem_we → 10. ex_rs[0]=0 with matches → 00.
- Load-use: ex_is_load=1, ex_rd=7, id_rs[1]=7, id_rs_used[1]=1 → pc_stall, if_id_stall, id_ex_bubble high exactly 1 cycle. Same with id_rs_used[1]=0 → no stall.
- Flush vs hazard: load-use condition plus ex_br_taken=1 → if_id_flush=1, id_ex_bubble=1, pc_stall=0.
- MD latency: MD_LATENCY=4, md issue at cycle N → md_busy/ex_hold high cycles N+1..N+3, low at N+4. Repeat with MD_LATENCY=1 → md_busy never high.
- Perf counters (macro defined): 3 load stalls, 1 MD op (latency 4), 2 flushes → perf_load_stalls=3, perf_md_stalls=3, perf_flushes=2.
